dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the single-cycle RV32I core. It sits on the far end of the core's data port, taking address, write data, op code and write enable. It serves byte, halfword and word loads and stores from on-chip RAM, applying sign or zero extension on reads. It also decodes a small memory-mapped I/O window containing:

- a free-running cycle counter,
- an LED register,
- a console transmit FIFO drained over a valid/ready byte interface.

## Interface

Parameters:
- ADDR_WIDTH, 16: RAM byte-address width; RAM holds 2**(ADDR_WIDTH-2) words.
- FIFO_DEPTH, 8: console TX FIFO entries; must be a power of two, at least 2.

Ports:
- clock  in  1  single clock; stores commit on rising edge, loads register on falling edge.
- reset  in  1  asynchronous, active-high.
- addr  in  32  byte address (core ALU result).
- datain  in  32  store data (core rs2).
- dataout  out  32  load data, extended per memop.
- memop  in  3  access size/sign, RV32I funct3 encoding.
- we  in  1  store enable.
- leds  out  16  LED register contents.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts head on a rising edge where tx_valid=1.

## Operation

Address decode:
- addr[31]=0 selects RAM. Word index is addr[ADDR_WIDTH-1:2]; upper bits are ignored, so addresses alias/wrap.
- addr[31]=1 selects MMIO, decoded on addr[3:2]; all other bits are ignored.

memop encoding:
- 000 = byte signed
- 001 = half signed
- 010 = word
- 100 = byte unsigned
- 101 = half unsigned
- 011/110/111 behave as word.
- Stores use only size (memop[1:0]), so 100 stores a byte and 101 stores a half.

Lane selection:
- Byte accesses use lane addr[1:0].
- Half accesses use lane addr[1]; addr[0] is ignored (no misalignment trap).
- Word accesses ignore addr[1:0].
- Stores write only the selected byte lanes; the other lanes are preserved.

Load extension:
- Signed ops replicate the top bit of the selected lane.
- Unsigned ops zero-fill.
- MMIO reads are extended with the same rules as RAM reads.

MMIO map:
- 0x8000_0000 CYCLE: read-only; 32-bit counter, +1 every rising edge, wraps at 0xFFFF_FFFF to 0. Writes are ignored.
- 0x8000_0004 LED: read/write, 16 bits. Reads return zero in bits 31:16. Sub-word stores update only the addressed lanes.
- 0x8000_0008 TXDATA: a store pushes datain[7:0] regardless of size. Reads return 0.
- 0x8000_000C STATUS: bit0 = empty, bit1 = full, bit2 = overflow (sticky). A store with datain[2]=1 clears overflow. Other bits read 0.

FIFO behaviour:
- Push when full: byte dropped, overflow set. A pop on the same edge frees a slot first, so the push is accepted and overflow stays unchanged.
- Push and pop on the same edge with the FIFO non-full: count unchanged, order preserved.
- tx_data and tx_valid come straight from FIFO state, with no extra register.

## Timing

Loads:
- dataout is registered on the falling edge of clock from the addr/memop present at that edge.
- It holds until the next falling edge, giving the core half a cycle of setup before the rising edge.

Stores and state updates:
- Stores commit on the rising edge when we=1.
- A load in the same cycle at the same address returns the old data.
- The CYCLE value loaded is the counter value at the falling edge.
- LED, FIFO and flag updates all happen on the rising edge.

Reset (asynchronous, effective immediately):
- dataout=0, leds=0, CYCLE=0, FIFO empty (tx_valid=0, tx_data=0), overflow=0.
- RAM contents are not reset.
- Reset asserted mid-cycle discards any pending store.
- Deassertion is sampled on the next edge.

## Structure

Shared package dmem_pkg holds:
- memop codes (MOP_B, MOP_H, MOP_W, MOP_BU, MOP_HU),
- MMIO base 0x8000_0000 and offsets CYCLE/LED/TXDATA/STATUS,
- STATUS bit indices.

One sub-module, dmem_tx_fifo:
- Parameterised on FIFO_DEPTH; synchronous push/pop with asynchronous reset.
- Outputs full, empty and head data.
- Uses pointer-plus-count form so simultaneous push/pop at full is handled.

Lane select, byte-enable generation and extension stay in the top level.

## Test plan

- sw 0x8765_4321 to 0x100, then lb/lbu at 0x103 and lh/lhu at 0x102, on successive cycles -> dataout 0xFFFF_FF87, 0x0000_0087, 0xFFFF_8765, 0x0000_8765.
- sw 0xAABB_CCDD to 0x40; sb 0x11 to 0x41; lw 0x40 -> 0xAABB_11DD. Then sh 0x2233 to 0x42; lw 0x40 -> 0x2233_11DD. Finally lw 0x40 + 2**ADDR_WIDTH -> same value (aliasing).
- Reset released, then lw 0x8000_0000 at two falling edges 5 cycles apart -> values differ by exactly 5. Force the counter to 0xFFFF_FFFF -> next read returns 0.
- tx_ready=0; push 9 bytes 0x41..0x49 -> STATUS reads 0x6 (full + overflow), and 0x49 is lost. Clear via STATUS store 0x4. Raise tx_ready -> 0x41..0x48 emerge in order, then STATUS reads 0x1.
- FIFO full with tx_ready=1; push 0x5A on the same edge as a pop -> accepted, overflow stays 0, 0x5A drains last.
- sh 0xBEEF to LED at 0x8000_0006, then sb 0x12 at 0x8000_0004 -> leds 0x0012 (the offset-6 write lands in bits 31:16, which are dropped). Assert reset mid-cycle with we=1 -> leds=0, dataout=0, tx_valid=0 immediately, and the store does not land.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: memop codes, MMIO map and status bit positions shared by the data-memory responder
package dmem_pkg;
  localparam logic [2:0] MOP_B  = 3'b000;
  localparam logic [2:0] MOP_H  = 3'b001;
  localparam logic [2:0] MOP_W  = 3'b010;
  localparam logic [2:0] MOP_BU = 3'b100;
  localparam logic [2:0] MOP_HU = 3'b101;
  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;
  localparam logic [3:0] OFF_CYCLE  = 4'h0;
  localparam logic [3:0] OFF_LED    = 4'h4;
  localparam logic [3:0] OFF_TXDATA = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
endpackage

// File: rtl/dmem_tx_fifo.sv
// dmem_tx_fifo: pointer-plus-count byte FIFO; a pop frees a slot for a push on the same edge
module dmem_tx_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          do_push, do_pop;
  assign full    = count == (PW+1)'(FIFO_DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? 8'h00 : mem[rd_ptr];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  always_ff @(posedge clock)
    if (do_push && !reset) mem[wr_ptr] <= din;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: RV32I data-port responder with byte-lane RAM, cycle counter, LED register and console TX FIFO
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  output logic [31:0] dataout,
  input  logic [2:0]  memop,
  input  logic        we,
  output logic [15:0] leds,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
  logic [31:0] ram [WORDS];
  logic [ADDR_WIDTH-3:0] widx;
  logic [31:0] cycle, wdata, mmio_word, raw, lane_data, load_val, status;
  logic [3:0]  be;
  logic [1:0]  sel;
  logic        is_mmio, is_byte, is_half, sign;
  logic        led_wr, push, pop, clr, overflow, fifo_full, fifo_empty;
  logic        unused_bits;
  assign unused_bits = &{1'b0, addr[30:ADDR_WIDTH]};
  assign is_mmio = addr[31] == MMIO_BASE[31];
  assign is_byte = memop[1:0] == MOP_B[1:0];
  assign is_half = memop[1:0] == MOP_H[1:0];
  assign widx    = addr[ADDR_WIDTH-1:2];
  assign sel     = addr[3:2];
  assign be      = is_byte ? 4'b0001 << addr[1:0] : is_half ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata   = is_byte ? {4{datain[7:0]}} : is_half ? {2{datain[15:0]}} : datain;
  always_comb begin
    status = '0;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_OVF]   = overflow;
  end
  assign mmio_word = sel == OFF_CYCLE[3:2]  ? cycle :
                     sel == OFF_LED[3:2]    ? {16'h0000, leds} :
                     sel == OFF_STATUS[3:2] ? status : 32'h0;
  assign raw       = is_mmio ? mmio_word : ram[widx];
  assign lane_data = raw >> (is_byte ? {addr[1:0], 3'b000} : is_half ? {addr[1], 4'b0000} : 5'd0);
  assign sign      = ~memop[2] & (is_byte ? lane_data[7] : lane_data[15]);
  assign load_val  = is_byte ? {{24{sign}}, lane_data[7:0]} :
                     is_half ? {{16{sign}}, lane_data[15:0]} : lane_data;
  // Loads register on the falling edge so the core sees them half a cycle before the store edge
  always_ff @(negedge clock or posedge reset)
    if (reset) dataout <= '0;
    else dataout <= load_val;
  always_ff @(posedge clock)
    if (we && !is_mmio && !reset)
      for (int i = 0; i < 4; i++)
        if (be[i]) ram[widx][8*i +: 8] <= wdata[8*i +: 8];
  assign led_wr   = we & is_mmio & (sel == OFF_LED[3:2]);
  assign push     = we & is_mmio & (sel == OFF_TXDATA[3:2]);
  assign clr      = we & is_mmio & (sel == OFF_STATUS[3:2]) & datain[ST_OVF];
  assign pop      = tx_valid & tx_ready;
  assign tx_valid = ~fifo_empty;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cycle    <= '0;
      leds     <= '0;
      overflow <= 1'b0;
    end else begin
      cycle <= cycle + 32'd1;
      if (led_wr) leds <= {be[1] ? wdata[15:8] : leds[15:8], be[0] ? wdata[7:0] : leds[7:0]};
      if (clr) overflow <= 1'b0;
      else if (push & fifo_full & ~pop) overflow <= 1'b1;
    end
  dmem_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(datain[7:0]),
    .dout(tx_data),
    .full(fifo_full),
    .empty(fifo_empty)
  );
endmodule
